// File: rtl/trigout_pkg.sv
// Shared constants for the trigger-out timestamp FIFO: Wishbone register
// word offsets, status/ctrl bit positions, timestamp field widths and the
// FIFO entry width helper.
package trigout_pkg;

   // Register word offsets (wb_adr_i[4:2])
   localparam logic [2:0] REG_STATUS   = 3'd0;
   localparam logic [2:0] REG_CTRL     = 3'd1;
   localparam logic [2:0] REG_HEAD_HI  = 3'd2;
   localparam logic [2:0] REG_HEAD_SEC = 3'd3;
   localparam logic [2:0] REG_HEAD_CYC = 3'd4;
   localparam logic [2:0] REG_DROP     = 3'd5;

   // Status register bit positions
   localparam int unsigned STAT_WR_ENABLE = 0;
   localparam int unsigned STAT_WR_LINK   = 1;
   localparam int unsigned STAT_WR_VALID  = 2;
   localparam int unsigned STAT_PRESENT   = 8;
   localparam int unsigned STAT_OVERFLOW  = 9;
   localparam int unsigned STAT_COUNT_LSB = 16;
   localparam int unsigned STAT_COUNT_W   = 9;

   // Ctrl register bit positions
   localparam int unsigned CTRL_EXT_EN = 8;
   localparam int unsigned CTRL_CLEAR  = 31;

   // Head-high register layout
   localparam int unsigned HEAD_MASK_LSB = 16;
   localparam int unsigned HEAD_EXT_BIT  = 24;

   // White Rabbit time widths
   localparam int unsigned SEC_W = 40;
   localparam int unsigned CYC_W = 28;

   typedef enum logic [1:0] {
      WB_IDLE,
      WB_DECODE,
      WB_UPDATE
   } wb_state_e;

   // Entry = {mask (channels + ext), seconds, cycles}
   function automatic int unsigned ts_entry_width(input int unsigned n_ch);
      return n_ch + 1 + SEC_W + CYC_W;
   endfunction

endpackage

// File: rtl/trigout_sync_fifo.sv
// Synchronous FIFO built on a register array with a show-ahead head output.
// Ports: clk_i/rst_n_i (sync active-low reset), push_i/data_i write side,
// pop_i read side, clear_i empties the FIFO (wins over push/pop),
// full_o/empty_o/count_o status, head_o entry at the read pointer (0 when empty).
module trigout_sync_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LOG2_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  push_i,
   input  logic [WIDTH-1:0]      data_i,
   input  logic                  pop_i,
   input  logic                  clear_i,
   output logic                  full_o,
   output logic                  empty_o,
   output logic [LOG2_DEPTH:0]   count_o,
   output logic [WIDTH-1:0]      head_o
);

   localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
   localparam int unsigned CNT_W = LOG2_DEPTH + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   // Pointer/count update; a push into a full FIFO only lands if a pop frees the slot
   always_comb begin
      do_push  = 1'b0;
      do_pop   = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         do_pop  = pop_i & ~empty_o;
         do_push = push_i & (~full_o | do_pop);
         if (do_push) wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: head_o is masked while empty
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/trigout_ts_fifo.sv
// Trigger-out timestamp FIFO. Stamps channel/external trigger events with
// WR time, queues them and exposes the queue on a Wishbone register bank.
// Ports: clk_i, rst_n_i (sync active-low); wb_* pipelined Wishbone slave;
// wr_enable_i/wr_link_i/wr_valid_i WR status; tm_sec_i/tm_cycles_i WR time;
// ch_trig_i/ext_trig_i trigger pulses; irq_o high while entries are queued.
module trigout_ts_fifo
   import trigout_pkg::*;
#(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned LOG2_DEPTH    = 4,
   parameter int unsigned REQUIRE_VALID = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [4:0]        wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_stall_o,
   output logic              wb_err_o,
   output logic              wb_rty_o,
   input  logic              wr_enable_i,
   input  logic              wr_link_i,
   input  logic              wr_valid_i,
   input  logic [39:0]       tm_sec_i,
   input  logic [27:0]       tm_cycles_i,
   input  logic [N_CH-1:0]   ch_trig_i,
   input  logic              ext_trig_i,
   output logic              irq_o
);

   localparam int unsigned ENTRY_W = ts_entry_width(N_CH);
   localparam int unsigned CNT_W   = LOG2_DEPTH + 1;
   localparam int unsigned MASK_W  = N_CH + 1;

   wb_state_e          state_q, state_d;
   logic [2:0]         adr_q, adr_d;
   logic               we_q, we_d;
   logic [31:0]        wdat_q, wdat_d;
   logic [CYC_W-1:0]   pop_cyc_q, pop_cyc_d;
   logic               ack_q, ack_d;
   logic [31:0]        rdat_q, rdat_d;
   logic [N_CH-1:0]    ch_en_q, ch_en_d;
   logic               ext_en_q, ext_en_d;
   logic               ovf_q, ovf_d;
   logic [31:0]        drop_q, drop_d;
   logic               irq_q, irq_d;

   logic               fifo_full, fifo_empty;
   logic [CNT_W-1:0]   fifo_count;
   logic [ENTRY_W-1:0] fifo_head;

   logic [MASK_W-1:0]  hit;
   logic               valid_ok, capture, accept, pop, clear, push, drop;
   logic [CYC_W-1:0]   head_cyc;
   logic [SEC_W-1:0]   head_sec;
   logic [MASK_W-1:0]  head_mask;
   logic [31:0]        status_w, ctrl_w, head_hi_w, rd_mux;
   logic               unused_ok;

   assign hit      = {ext_trig_i & ext_en_q, ch_trig_i & ch_en_q};
   assign valid_ok = (REQUIRE_VALID == 0) ? 1'b1 : wr_valid_i;
   assign capture  = (|hit) & valid_ok;
   assign accept   = (state_q == WB_IDLE) & wb_cyc_i & wb_stb_i;
   // Head pops on the request edge; its cycles field is snapshotted on that same edge
   assign pop      = accept & ~wb_we_i & (wb_adr_i[4:2] == REG_HEAD_CYC) & ~fifo_empty;
   assign clear    = (state_q == WB_UPDATE) & wdat_q[CTRL_CLEAR];
   assign push     = capture & ~clear;
   assign drop     = push & fifo_full & ~pop;

   assign head_cyc  = fifo_head[CYC_W-1:0];
   assign head_sec  = fifo_head[CYC_W +: SEC_W];
   assign head_mask = fifo_head[CYC_W+SEC_W +: MASK_W];

   trigout_sync_fifo #(
      .WIDTH      (ENTRY_W),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push),
      .data_i  ({hit, tm_sec_i, tm_cycles_i}),
      .pop_i   (pop),
      .clear_i (clear),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   // Register views
   always_comb begin
      status_w = '0;
      status_w[STAT_WR_ENABLE] = wr_enable_i;
      status_w[STAT_WR_LINK]   = wr_link_i;
      status_w[STAT_WR_VALID]  = wr_valid_i;
      status_w[STAT_PRESENT]   = ~fifo_empty;
      status_w[STAT_OVERFLOW]  = ovf_q;
      status_w[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);

      ctrl_w = '0;
      ctrl_w[N_CH-1:0]   = ch_en_q;
      ctrl_w[CTRL_EXT_EN] = ext_en_q;

      head_hi_w = '0;
      head_hi_w[7:0] = head_sec[SEC_W-1 -: 8];
      head_hi_w[HEAD_MASK_LSB +: N_CH] = head_mask[N_CH-1:0];
      head_hi_w[HEAD_EXT_BIT] = head_mask[N_CH];
   end

   // Read mux, evaluated in the decode phase
   always_comb begin
      rd_mux = '0;
      case (adr_q)
         REG_STATUS:   rd_mux = status_w;
         REG_CTRL:     rd_mux = ctrl_w;
         REG_HEAD_HI:  rd_mux = head_hi_w;
         REG_HEAD_SEC: rd_mux = head_sec[31:0];
         REG_HEAD_CYC: rd_mux = 32'(pop_cyc_q);
         REG_DROP:     rd_mux = drop_q;
         default:      rd_mux = '0;
      endcase
   end

   // Bus FSM, ctrl register, overflow and drop counter next-state
   always_comb begin
      state_d   = state_q;
      adr_d     = adr_q;
      we_d      = we_q;
      wdat_d    = wdat_q;
      pop_cyc_d = pop_cyc_q;
      ack_d     = 1'b0;
      rdat_d    = rdat_q;
      ch_en_d   = ch_en_q;
      ext_en_d  = ext_en_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      irq_d     = ~fifo_empty;

      case (state_q)
         WB_IDLE: begin
            if (accept) begin
               state_d   = WB_DECODE;
               adr_d     = wb_adr_i[4:2];
               we_d      = wb_we_i;
               wdat_d    = wb_dat_i;
               pop_cyc_d = head_cyc;
            end
         end
         WB_DECODE: begin
            if (we_q && (adr_q == REG_CTRL)) begin
               state_d = WB_UPDATE;
            end else begin
               state_d = WB_IDLE;
               ack_d   = 1'b1;
               if (!we_q) rdat_d = rd_mux;
               if (we_q && (adr_q == REG_STATUS) && wdat_q[STAT_OVERFLOW]) ovf_d = 1'b0;
            end
         end
         WB_UPDATE: begin
            state_d  = WB_IDLE;
            ack_d    = 1'b1;
            ch_en_d  = wdat_q[N_CH-1:0];
            ext_en_d = wdat_q[CTRL_EXT_EN];
            if (clear) ovf_d = 1'b0;
         end
         default: state_d = WB_IDLE;
      endcase

      // A drop sets overflow even against a same-cycle software clear
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= WB_IDLE;
         adr_q     <= '0;
         we_q      <= 1'b0;
         wdat_q    <= '0;
         pop_cyc_q <= '0;
         ack_q     <= 1'b0;
         rdat_q    <= '0;
         ch_en_q   <= '0;
         ext_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
         drop_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         adr_q     <= adr_d;
         we_q      <= we_d;
         wdat_q    <= wdat_d;
         pop_cyc_q <= pop_cyc_d;
         ack_q     <= ack_d;
         rdat_q    <= rdat_d;
         ch_en_q   <= ch_en_d;
         ext_en_q  <= ext_en_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
         irq_q     <= irq_d;
      end
   end

   assign wb_dat_o   = rdat_q;
   assign wb_ack_o   = ack_q;
   assign wb_stall_o = (state_q != WB_IDLE) & ~ack_q;
   assign wb_err_o   = 1'b0;
   assign wb_rty_o   = 1'b0;
   assign irq_o      = irq_q;

   // Byte lanes, low address bits and unused write-data bits carry no function
   assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0], wdat_q};

endmodule

// File: tb/tb_trigout_ts_fifo.sv
// Self-checking bench for trigout_ts_fifo: directed scenarios followed by
// randomized triggers and bus traffic, compared against a queue-based model.
module tb_trigout_ts_fifo;

   localparam int unsigned N_CH       = 4;
   localparam int unsigned LOG2_DEPTH = 4;
   localparam int unsigned DEPTH      = 16;

   logic              clk;
   logic              rst_n_i;
   logic              wb_cyc_i, wb_stb_i, wb_we_i;
   logic [4:0]        wb_adr_i;
   logic [3:0]        wb_sel_i;
   logic [31:0]       wb_dat_i;
   logic [31:0]       wb_dat_o;
   logic              wb_ack_o, wb_stall_o, wb_err_o, wb_rty_o;
   logic              wr_enable_i, wr_link_i, wr_valid_i;
   logic [39:0]       tm_sec_i;
   logic [27:0]       tm_cycles_i;
   logic [N_CH-1:0]   ch_trig_i;
   logic              ext_trig_i;
   logic              irq_o;

   trigout_ts_fifo #(
      .N_CH          (N_CH),
      .LOG2_DEPTH    (LOG2_DEPTH),
      .REQUIRE_VALID (1)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_we_i     (wb_we_i),
      .wb_adr_i    (wb_adr_i),
      .wb_sel_i    (wb_sel_i),
      .wb_dat_i    (wb_dat_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .wb_stall_o  (wb_stall_o),
      .wb_err_o    (wb_err_o),
      .wb_rty_o    (wb_rty_o),
      .wr_enable_i (wr_enable_i),
      .wr_link_i   (wr_link_i),
      .wr_valid_i  (wr_valid_i),
      .tm_sec_i    (tm_sec_i),
      .tm_cycles_i (tm_cycles_i),
      .ch_trig_i   (ch_trig_i),
      .ext_trig_i  (ext_trig_i),
      .irq_o       (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   typedef struct {
      logic [N_CH:0] mask;
      logic [39:0]   sec;
      logic [27:0]   cyc;
   } ev_t;

   ev_t             q[$];
   bit              m_ovf;
   int unsigned     m_drop;
   logic [N_CH-1:0] m_ch_en;
   logic            m_ext_en;

   int errors = 0;
   int checks = 0;
   int reqs   = 0;
   int ack_cnt = 0;
   logic [39:0] last_sec;
   logic [27:0] last_cyc;

   always @(posedge clk) if (wb_ack_o === 1'b1) ack_cnt++;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf    = 1'b0;
      m_drop   = 0;
      m_ch_en  = '0;
      m_ext_en = 1'b0;
   endtask

   // One clock edge of the model: optional pop, then a possible capture
   task automatic model_edge(input bit pop, input logic [N_CH-1:0] ch, input logic ext,
                             input logic [39:0] sec, input logic [27:0] cyc);
      logic [N_CH:0] hit;
      ev_t e;
      hit = {ext & m_ext_en, ch & m_ch_en};
      if (pop && q.size() > 0) void'(q.pop_front());
      if (hit != 0 && wr_valid_i) begin
         if (q.size() < DEPTH) begin
            e.mask = hit;
            e.sec  = sec;
            e.cyc  = cyc;
            q.push_back(e);
         end else begin
            m_ovf = 1'b1;
            if (m_drop != 32'hFFFF_FFFF) m_drop++;
         end
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [2:0] idx);
      logic [31:0] v;
      bit present;
      v = '0;
      present = (q.size() != 0);
      case (idx)
         3'd0: v = {7'd0, 9'(q.size()), 6'd0, m_ovf, present, 5'd0, wr_valid_i, wr_link_i, wr_enable_i};
         3'd1: v = {23'd0, m_ext_en, 4'd0, m_ch_en};
         3'd2: if (present) v = {7'd0, q[0].mask[N_CH], 4'd0, q[0].mask[N_CH-1:0], 8'd0, q[0].sec[39:32]};
         3'd3: if (present) v = q[0].sec[31:0];
         3'd4: if (present) v = {4'd0, q[0].cyc};
         3'd5: v = m_drop;
         default: v = '0;
      endcase
      return v;
   endfunction

   task automatic trig(input logic [N_CH-1:0] ch, input logic ext,
                       input logic [39:0] sec, input logic [27:0] cyc);
      ch_trig_i   = ch;
      ext_trig_i  = ext;
      tm_sec_i    = sec;
      tm_cycles_i = cyc;
      tick();
      model_edge(1'b0, ch, ext, sec, cyc);
      ch_trig_i  = '0;
      ext_trig_i = 1'b0;
   endtask

   // Single bus access, with optional triggers presented in the request cycle
   task automatic wb_access(input bit we, input logic [2:0] idx, input logic [31:0] wdat,
                            input logic [N_CH-1:0] ch, input logic ext, output logic [31:0] rdat);
      logic [31:0] exp;
      int n;
      bit head_pop;
      head_pop = !we && (idx == 3'd4);
      exp = exp_read(3'd4);
      wb_cyc_i    = 1'b1;
      wb_stb_i    = 1'b1;
      wb_we_i     = we;
      wb_adr_i    = {idx, 2'b00};
      wb_dat_i    = wdat;
      wb_sel_i    = 4'hF;
      tm_sec_i    = {8'($urandom), 32'($urandom)};
      tm_cycles_i = 28'($urandom);
      ch_trig_i   = ch;
      ext_trig_i  = ext;
      tick();
      reqs++;
      model_edge(head_pop, ch, ext, tm_sec_i, tm_cycles_i);
      last_sec   = tm_sec_i;
      last_cyc   = tm_cycles_i;
      wb_cyc_i   = 1'b0;
      wb_stb_i   = 1'b0;
      wb_we_i    = 1'b0;
      ch_trig_i  = '0;
      ext_trig_i = 1'b0;
      if (!head_pop) exp = exp_read(idx);
      n = 0;
      do begin
         tick();
         n++;
      end while (wb_ack_o !== 1'b1 && n < 6);
      check_eq(we ? "wr_ack_latency" : "rd_ack_latency", 32'(n), (we && idx == 3'd1) ? 32'd2 : 32'd1);
      rdat = wb_dat_o;
      if (!we) begin
         check_eq($sformatf("rd_0x%02h", {idx, 2'b00}), rdat, exp);
      end else begin
         if (idx == 3'd0 && wdat[9]) m_ovf = 1'b0;
         if (idx == 3'd1) begin
            m_ch_en  = wdat[N_CH-1:0];
            m_ext_en = wdat[8];
            if (wdat[31]) begin
               q.delete();
               m_ovf = 1'b0;
            end
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [27:0] tail_cyc;
      wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
      wr_enable_i = 0; wr_link_i = 0; wr_valid_i = 1;
      tm_sec_i = '0; tm_cycles_i = '0; ch_trig_i = '0; ext_trig_i = 0;
      last_sec = '0; last_cyc = '0;
      model_reset();
      rst_n_i = 1'b0;
      repeat (3) tick();
      check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
      check_eq("rst_dat", wb_dat_o, 32'd0);
      check_eq("rst_irq", 32'(irq_o), 32'd0);
      check_eq("rst_stall", 32'(wb_stall_o), 32'd0);
      rst_n_i = 1'b1;
      tick();

      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("status_after_reset", r, 32'h0000_0004);
      wb_access(0, 3'd1, 0, '0, 0, r);  check_eq("ctrl_after_reset", r, 32'h0);

      // Coincident ch0+ch2 capture
      wb_access(1, 3'd1, 32'h105, '0, 0, r);
      trig(4'b0101, 1'b0, 40'h12_3456789A, 28'h0ABCDEF);
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("status_one", r, 32'h0001_0104);
      wb_access(0, 3'd2, 0, '0, 0, r);  check_eq("head_hi", r, 32'h0005_0012);
      wb_access(0, 3'd3, 0, '0, 0, r);  check_eq("head_sec", r, 32'h3456_789A);
      wb_access(0, 3'd4, 0, '0, 0, r);  check_eq("head_cyc", r, 32'h00AB_CDEF);
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("status_popped", r, 32'h0000_0004);
      tick();
      check_eq("irq_empty", 32'(irq_o), 32'd0);
      wb_access(0, 3'd4, 0, '0, 0, r);  check_eq("pop_empty", r, 32'h0);

      // Disabled channel
      wb_access(1, 3'd1, 32'h001, '0, 0, r);
      trig(4'b0010, 1'b0, 40'h1, 28'h2);
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("disabled_ch", r, 32'h0000_0004);

      // Fill and overflow
      for (int i = 0; i < DEPTH + 3; i++) trig(4'b0001, 1'b0, 40'(i + 100), 28'(i + 7));
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("status_full_ovf", r, 32'h0010_0304);
      wb_access(0, 3'd5, 0, '0, 0, r);  check_eq("drop_count", r, 32'd3);
      check_eq("irq_full", 32'(irq_o), 32'd1);
      wb_access(1, 3'd0, 32'h200, '0, 0, r);
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("ovf_cleared", r, 32'h0010_0104);

      // Push and pop on the same edge while full
      wb_access(0, 3'd4, 0, 4'b0001, 0, r);
      tail_cyc = last_cyc;
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("full_pushpop_count", r, 32'h0010_0104);
      wb_access(0, 3'd5, 0, '0, 0, r);  check_eq("full_pushpop_drop", r, 32'd3);
      for (int i = 0; i < DEPTH - 1; i++) wb_access(0, 3'd4, 0, '0, 0, r);
      wb_access(0, 3'd4, 0, '0, 0, r);  check_eq("tail_entry", r, {4'd0, tail_cyc});
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("drained", r, 32'h0000_0004);

      // Valid gate, then FIFO clear
      wr_valid_i = 1'b0;
      trig(4'b0001, 1'b0, 40'h5, 28'h6);
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("valid_gate", r, 32'h0);
      wr_valid_i = 1'b1;
      trig(4'b0001, 1'b0, 40'h7, 28'h8);
      trig(4'b0001, 1'b0, 40'h9, 28'hA);
      tick();
      check_eq("irq_before_clear", 32'(irq_o), 32'd1);
      wb_access(1, 3'd1, 32'h8000_0001, '0, 0, r);
      check_eq("irq_lag", 32'(irq_o), 32'd1);
      tick();
      check_eq("irq_after_clear", 32'(irq_o), 32'd0);
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("status_cleared", r, 32'h0000_0004);
      wb_access(0, 3'd1, 0, '0, 0, r);  check_eq("ctrl_clear_reads0", r, 32'h0000_0001);

      // Randomized traffic
      for (int it = 0; it < 400; it++) begin
         int sel;
         logic [2:0] idx;
         logic [N_CH-1:0] ch;
         logic ext;
         logic [31:0] wd;
         sel = $urandom_range(0, 9);
         wr_enable_i = 1'($urandom);
         wr_link_i   = 1'($urandom);
         wr_valid_i  = ($urandom_range(0, 9) != 0);
         ch  = ($urandom_range(0, 1) == 0) ? N_CH'($urandom) : '0;
         ext = 1'($urandom);
         idx = 3'($urandom);
         if (sel <= 4) begin
            trig(N_CH'($urandom), 1'($urandom), {8'($urandom), 32'($urandom)}, 28'($urandom));
         end else if (sel <= 7) begin
            wb_access(0, idx, 0, ch, ext, r);
         end else if (sel == 8) begin
            wd = ($urandom & 32'h1FF) | (($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'h0);
            wb_access(1, 3'd1, wd, ch, ext, r);
         end else begin
            wd = $urandom;
            if (idx == 3'd1) idx = 3'd0;
            wb_access(1, idx, wd, ch, ext, r);
         end
         tick();
         check_eq("irq_track", 32'(irq_o), 32'(q.size() != 0));
      end

      tick();
      check_eq("one_ack_per_req", 32'(ack_cnt), 32'(reqs));

      // Reset in the middle of an access: no ack must follow
      wr_enable_i = 0; wr_link_i = 0; wr_valid_i = 1;
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 5'h00;
      tick();
      wb_cyc_i = 0; wb_stb_i = 0;
      rst_n_i = 1'b0;
      tick();
      check_eq("midreset_ack1", 32'(wb_ack_o), 32'd0);
      tick();
      check_eq("midreset_ack2", 32'(wb_ack_o), 32'd0);
      check_eq("midreset_irq", 32'(irq_o), 32'd0);
      rst_n_i = 1'b1;
      model_reset();
      tick();
      wb_access(0, 3'd0, 0, '0, 0, r);  check_eq("status_after_midreset", r, 32'h0000_0004);
      wb_access(0, 3'd5, 0, '0, 0, r);  check_eq("drop_after_midreset", r, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
